// File: rtl/surf4_debug_regs.sv
// surf4_debug_regs: Wishbone slave register block on the debug bus.
// It provides the ILA0 mux select, static debug bits, one-shot debug pulses,
// an event counter and a scratch register.
//
// Handshake: a request is cyc_i & stb_i while no termination is showing.
// The cycle after a request shows exactly one of ack_o or err_o for one cycle.
// err_o is used for unmapped addresses. Read data is on dat_o only in the
// ack cycle. Write side effects land on the edge that raises ack_o.
// A held stb_i is not a request during the termination cycle, so back-to-back
// accesses run at one per two cycles.
module surf4_debug_regs #(
    parameter int          ADR_WIDTH   = 20,
    parameter logic [31:0] IDENT       = 32'h53444247,
    parameter int          EVCNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [ADR_WIDTH-1:0] adr_i,
    input  logic [31:0]          dat_i,
    output logic [31:0]          dat_o,
    output logic                 ack_o,
    output logic                 err_o,
    output logic                 rty_o,
    input  logic                 event_i,
    output logic [1:0]           ila0_sel_o,
    output logic [7:0]           global_debug_o,
    output logic [7:0]           pulse_o
);

    localparam logic [3:0] IDX_ID      = 4'd0;
    localparam logic [3:0] IDX_CTRL    = 4'd1;
    localparam logic [3:0] IDX_PULSE   = 4'd2;
    localparam logic [3:0] IDX_EVCNT   = 4'd3;
    localparam logic [3:0] IDX_SCRATCH = 4'd4;

    logic [3:0]             reg_idx;
    logic                   mapped;
    logic                   req;
    logic                   wr_hit;
    logic [31:0]            rd_data;
    logic [31:0]            evcnt_ext;
    logic [31:0]            scratch_q;
    logic [EVCNT_WIDTH-1:0] evcnt_q;
    logic                   ev_s0, ev_s1, ev_s2;
    logic                   ev_rise;
    logic                   evcnt_clr;
    logic                   unused_adr_lsb;

    // Byte lanes are not decoded; only full-word accesses exist.
    assign unused_adr_lsb = ^adr_i[1:0];

    assign rty_o   = 1'b0;
    assign reg_idx = adr_i[5:2];
    assign mapped  = (adr_i[ADR_WIDTH-1:6] == '0) && (reg_idx < 4'd5);
    assign req     = cyc_i & stb_i & ~ack_o & ~err_o;
    assign wr_hit  = req & mapped & we_i;
    assign ev_rise = ev_s1 & ~ev_s2;
    assign evcnt_clr = wr_hit && (reg_idx == IDX_EVCNT);

    // Read mux over the mapped registers; write-only and unmapped slots read 0.
    always_comb begin
        evcnt_ext = '0;
        evcnt_ext[EVCNT_WIDTH-1:0] = evcnt_q;
        rd_data = '0;
        case (reg_idx)
            IDX_ID:      rd_data = IDENT;
            IDX_CTRL:    rd_data = {16'h0000, global_debug_o, 6'b000000, ila0_sel_o};
            IDX_EVCNT:   rd_data = evcnt_ext;
            IDX_SCRATCH: rd_data = scratch_q;
            default:     rd_data = '0;
        endcase
    end

    // Bus termination and registered read data, one cycle after the request.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= req & mapped;
            err_o <= req & ~mapped;
            dat_o <= (req & mapped & ~we_i) ? rd_data : 32'h0;
        end
    end

    // Control and scratch registers are updated on the acknowledging edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ila0_sel_o     <= '0;
            global_debug_o <= '0;
            scratch_q      <= '0;
        end else if (wr_hit) begin
            if (reg_idx == IDX_CTRL) begin
                ila0_sel_o     <= dat_i[1:0];
                global_debug_o <= dat_i[15:8];
            end
            if (reg_idx == IDX_SCRATCH) begin
                scratch_q <= dat_i;
            end
        end
    end

    // A pulse write shows its byte on pulse_o only during the ack cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            pulse_o <= '0;
        end else begin
            pulse_o <= (wr_hit && (reg_idx == IDX_PULSE)) ? dat_i[7:0] : 8'h00;
        end
    end

    // Two-flop synchronizer for event_i plus one flop for the edge detect.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ev_s0 <= 1'b0;
            ev_s1 <= 1'b0;
            ev_s2 <= 1'b0;
        end else begin
            ev_s0 <= event_i;
            ev_s1 <= ev_s0;
            ev_s2 <= ev_s1;
        end
    end

    // Saturating event counter.
    // A clear that coincides with an edge is applied first, then the edge counts.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            evcnt_q <= '0;
        end else if (evcnt_clr) begin
            evcnt_q <= ev_rise ? EVCNT_WIDTH'(1) : '0;
        end else if (ev_rise && (evcnt_q != {EVCNT_WIDTH{1'b1}})) begin
            evcnt_q <= evcnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_surf4_debug_regs.sv
// tb_surf4_debug_regs: drives surf4_debug_regs with directed and randomized
// bus traffic and event toggles.
// A behavioural model predicts every output in every cycle.
module tb_surf4_debug_regs;

    localparam int AW   = 20;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i, cyc_i, stb_i, we_i, event_i;
    logic [AW-1:0] adr_i;
    logic [31:0]   dat_i, dat_o;
    logic          ack_o, err_o, rty_o;
    logic [1:0]    ila0_sel_o;
    logic [7:0]    global_debug_o, pulse_o;

    surf4_debug_regs #(.ADR_WIDTH(AW), .IDENT(32'h53444247), .EVCNT_WIDTH(CW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
        .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
        .rty_o(rty_o), .event_i(event_i), .ila0_sel_o(ila0_sel_o),
        .global_debug_o(global_debug_o), .pulse_o(pulse_o)
    );

    // ---------------- clock ----------------
    always #5 clk_i = ~clk_i;

    // ---------------- model state ----------------
    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    bit   chk_on = 0;
    bit   ev_auto = 0;
    // expectations for the current cycle (e_) and the next cycle (n_)
    logic        e_ack = 0, e_err = 0, n_ack = 0, n_err = 0;
    logic [31:0] e_dat = 0, n_dat = 0;
    logic [7:0]  e_pulse = 0, n_pulse = 0, e_gd = 0, m_gd = 0;
    logic [1:0]  e_ila = 0, m_ila = 0;
    logic [31:0] m_scr = 0;
    int          rises[$];        // cycle numbers at which event_i went high
    int          clr_edge = 0;    // edge number of the last counter clear
    logic [31:0] exp_q[$];        // expected read data, in issue order

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, act, exp, cyc_n);
        end
    endtask

    // A rise raised after edge n is counted at edge n+3.
    // A clear at edge c discards every rise counted before c.
    function automatic int count_at(input int m);
        int c = 0;
        foreach (rises[i])
            if (rises[i] + 3 >= clr_edge && rises[i] + 3 <= m) c++;
        return (c > CMAX) ? CMAX : c;
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return 32'h53444247;
            1: return {16'h0, m_gd, 6'h0, m_ila};
            3: return 32'(count_at(cyc_n));
            4: return m_scr;
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk_i) begin
        if (chk_on) begin
            chk("ack_o", {31'h0, ack_o}, {31'h0, e_ack});
            chk("err_o", {31'h0, err_o}, {31'h0, e_err});
            chk("rty_o", {31'h0, rty_o}, 32'h0);
            chk("dat_o", dat_o, e_dat);
            chk("pulse_o", {24'h0, pulse_o}, {24'h0, e_pulse});
            chk("ila0_sel_o", {30'h0, ila0_sel_o}, {30'h0, e_ila});
            chk("global_debug_o", {24'h0, global_debug_o}, {24'h0, e_gd});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ev_set(input bit v);
        if (v && !event_i) rises.push_back(cyc_n);
        event_i = v;
    endtask

    task automatic tick();
        if (ev_auto && $urandom_range(0, 2) == 0) ev_set(!event_i);
        @(posedge clk_i);
        cyc_n++;
        #1;
        e_ack = n_ack; e_err = n_err; e_dat = n_dat; e_pulse = n_pulse;
        e_ila = m_ila; e_gd = m_gd;
        n_ack = 0; n_err = 0; n_dat = 0; n_pulse = 0;
    endtask

    task automatic access(input bit we, input logic [AW-1:0] adr, input logic [31:0] d,
                          input bit hold, output logic [31:0] rd);
        int  idx;
        bit  mp;
        logic [31:0] e;
        cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = d;
        idx = int'(adr[5:2]);
        mp = (adr[AW-1:6] == '0) && (idx < 5);
        if (!mp) begin
            n_err = 1;
        end else begin
            n_ack = 1;
            if (!we) begin
                n_dat = model_read(idx);
                exp_q.push_back(n_dat);
            end else begin
                case (idx)
                    1: begin m_ila = d[1:0]; m_gd = d[15:8]; end
                    2: n_pulse = d[7:0];
                    3: clr_edge = cyc_n + 1;
                    4: m_scr = d;
                    default: ;
                endcase
            end
        end
        tick();
        rd = dat_o;
        if (mp && !we) begin
            e = exp_q.pop_front();
            chk("read_data", rd, e);
        end
        if (!hold) begin
            cyc_i = 0; stb_i = 0;
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        logic [31:0] rd;
        bit          prev_hold;
        rst_n_i = 0; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; dat_i = '0; event_i = 0;
        tick();
        chk_on = 1;
        tick();
        rst_n_i = 1;
        tick();

        // ID register
        access(0, 'h0, 0, 0, rd);
        chk("id_literal", rd, 32'h53444247);
        access(1, 'h0, 32'h12345678, 0, rd);
        access(0, 'h3, 0, 0, rd);
        chk("id_after_write", rd, 32'h53444247);

        // scratch and control
        access(1, 'h10, 32'hDEADBEEF, 0, rd);
        access(0, 'h10, 0, 0, rd);
        chk("scratch_literal", rd, 32'hDEADBEEF);
        access(1, 'h04, 32'hFFFFA503, 0, rd);
        chk("ila_literal", {30'h0, ila0_sel_o}, 32'h3);
        chk("gd_literal", {24'h0, global_debug_o}, 32'hA5);
        access(0, 'h04, 0, 0, rd);
        chk("ctrl_literal", rd, 32'h0000A503);

        // pulse register
        access(1, 'h08, 32'h000000C3, 0, rd);
        access(0, 'h08, 0, 0, rd);
        chk("pulse_read_literal", rd, 32'h0);

        // event counter: five slow toggles
        for (int i = 0; i < 5; i++) begin
            ev_set(1); repeat (4) tick();
            ev_set(0); repeat (4) tick();
        end
        access(0, 'h0C, 0, 0, rd);
        chk("evcnt_five", rd, 32'd5);
        access(1, 'h0C, 32'hFFFFFFFF, 0, rd);
        access(0, 'h0C, 0, 0, rd);
        chk("evcnt_cleared", rd, 32'd0);

        // saturation
        for (int i = 0; i < CMAX + 5; i++) begin
            ev_set(1); tick(); ev_set(0); tick();
        end
        repeat (4) tick();
        access(0, 'h0C, 0, 0, rd);
        chk("evcnt_saturated", rd, 32'(CMAX));

        // clear coinciding with an edge-detect cycle
        ev_set(1); tick(); tick();
        access(1, 'h0C, 0, 0, rd);
        ev_set(0); repeat (3) tick();
        access(0, 'h0C, 0, 0, rd);
        chk("evcnt_clear_then_count", rd, 32'd1);

        // unmapped accesses leave state alone
        access(1, 'h14, 32'h0, 0, rd);
        access(1, 'h40000, 32'h0, 0, rd);
        access(1, 'h40010, 32'h0, 0, rd);
        access(0, 'h40000, 0, 0, rd);
        access(0, 'h04, 0, 0, rd);
        chk("ctrl_after_err", rd, 32'h0000A503);
        access(0, 'h10, 0, 0, rd);
        chk("scratch_after_err", rd, 32'hDEADBEEF);

        // stb held high across three reads
        access(0, 'h00, 0, 1, rd);
        access(0, 'h10, 0, 1, rd);
        access(0, 'h04, 0, 0, rd);
        chk("b2b_last", rd, 32'h0000A503);

        // randomized traffic with random event toggles
        ev_auto = 1;
        prev_hold = 0;
        for (int i = 0; i < 250; i++) begin
            logic [AW-1:0] a;
            bit h;
            a = '0;
            a[5:2] = 4'($urandom_range(0, 9));
            a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a[AW-1:6] = 14'($urandom_range(1, 16383));
            h = (i < 249) && ($urandom_range(0, 3) == 0);
            if (!prev_hold && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
            access(1'($urandom_range(0, 1)), a, $urandom, h, rd);
            prev_hold = h;
        end
        ev_auto = 0;
        ev_set(0);
        repeat (4) tick();

        // reset asserted while a write request is pending
        access(1, 'h10, 32'hCAFEF00D, 0, rd);
        rst_n_i = 0;
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 'h04; dat_i = 32'hFFFFFFFF;
        m_ila = 0; m_gd = 0; m_scr = 0; rises.delete(); clr_edge = 0;
        tick();
        cyc_i = 0; stb_i = 0;
        tick();
        rst_n_i = 1;
        tick();
        chk("ila_after_reset", {30'h0, ila0_sel_o}, 32'h0);
        access(0, 'h04, 0, 0, rd);
        chk("ctrl_after_reset", rd, 32'h0);
        access(0, 'h10, 0, 0, rd);
        chk("scratch_after_reset", rd, 32'h0);
        access(0, 'h0C, 0, 0, rd);
        chk("evcnt_after_reset", rd, 32'h0);

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
